// File: rtl/row_buffer_5tap.sv
// One-row pixel buffer with a 5-tap horizontal window read port.
// Taps beyond either row end read as zero; reads see pre-write data.
module row_buffer_5tap #(
  parameter int PIX_W   = 8,
  parameter int MAX_COL = 640
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PIX_W-1:0]   data,
  input  logic               write_en,
  input  logic               read_en,
  output logic [5*PIX_W-1:0] extended_data
);

  localparam int CW = $clog2(MAX_COL);

  localparam logic [CW-1:0] LAST  = CW'(MAX_COL - 1);
  localparam logic [CW-1:0] LAST1 = CW'(MAX_COL - 2);
  localparam logic [CW-1:0] LAST2 = CW'(MAX_COL - 3);
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] TWO   = CW'(2);

  logic [PIX_W-1:0] mem [MAX_COL];
  logic [CW-1:0]    wr_col;
  logic [CW-1:0]    rd_col;
  logic [PIX_W-1:0] tap_m2;
  logic [PIX_W-1:0] tap_m1;
  logic [PIX_W-1:0] tap_c;
  logic [PIX_W-1:0] tap_p1;
  logic [PIX_W-1:0] tap_p2;

  // Pixel storage; deliberately not reset.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[wr_col] <= data;
    end
  end

  // Write pointer advances on each stored pixel, wrapping at row end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_col <= '0;
    end else if (write_en) begin
      wr_col <= (wr_col == LAST) ? '0 : wr_col + ONE;
    end
  end

  // Five combinational taps with zero padding outside the row.
  always_comb begin
    tap_m2 = '0;
    tap_m1 = '0;
    tap_p1 = '0;
    tap_p2 = '0;
    tap_c  = mem[rd_col];
    if (rd_col >= TWO) begin
      tap_m2 = mem[rd_col - TWO];
    end
    if (rd_col >= ONE) begin
      tap_m1 = mem[rd_col - ONE];
    end
    if (rd_col <= LAST1) begin
      tap_p1 = mem[rd_col + ONE];
    end
    if (rd_col <= LAST2) begin
      tap_p2 = mem[rd_col + TWO];
    end
  end

  // Register the window and advance the read pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_col        <= '0;
      extended_data <= '0;
    end else if (read_en) begin
      extended_data <= {tap_m2, tap_m1, tap_c, tap_p1, tap_p2};
      rd_col        <= (rd_col == LAST) ? '0 : rd_col + ONE;
    end
  end

endmodule

// File: tb/tb_row_buffer_5tap.sv
// Scoreboard bench for row_buffer_5tap.
// Expected windows come from a bench-side row model.
module tb_row_buffer_5tap;

  localparam int NC = 640;

  logic        clk;
  logic        reset;
  logic [7:0]  data;
  logic        write_en;
  logic        read_en;
  logic [39:0] extended_data;

  logic [7:0]  model [NC];
  logic [39:0] sb [$];
  int          wr;
  int          rd;
  int          n_cmp;
  int          n_err;

  row_buffer_5tap dut (
    .clk          (clk),
    .reset        (reset),
    .data         (data),
    .write_en     (write_en),
    .read_en      (read_en),
    .extended_data(extended_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [39:0] got,
                     input logic [39:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %010h want %010h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] win(input int c);
    logic [39:0] r;
    int idx;
    r = '0;
    for (int k = 0; k < 5; k++) begin
      idx = c - 2 + k;
      r = r << 8;
      if (idx >= 0 && idx < NC) r[7:0] = model[idx];
    end
    return win_ret(r);
  endfunction

  function automatic logic [39:0] win_ret(input logic [39:0] v);
    return v;
  endfunction

  // One clock: drive, update model, compare scoreboard head after edge.
  task automatic step(input bit w, input logic [7:0] d, input bit r);
    logic [39:0] e;
    write_en = w;
    data     = d;
    read_en  = r;
    if (r) begin
      sb.push_back(win(rd));
      rd = (rd + 1) % NC;
    end
    if (w) begin
      model[wr] = d;
      wr = (wr + 1) % NC;
    end
    @(posedge clk);
    #1;
    write_en = 1'b0;
    read_en  = 1'b0;
    if (r) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_empty: got none want entry");
      end else begin
        e = sb.pop_front();
        chk("win", extended_data, e);
      end
    end
  endtask

  // Asynchronous pulse between clock edges.
  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    #1;
    chk(tag, extended_data, 40'h0);
    wr = 0;
    rd = 0;
    sb.delete();
    #1;
    reset = 1'b0;
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    wr       = 0;
    rd       = 0;
    reset    = 1'b1;
    data     = '0;
    write_en = 1'b0;
    read_en  = 1'b0;
    for (int i = 0; i < NC; i++) model[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_init", extended_data, 40'h0);
    reset = 1'b0;

    step(1, 8'h11, 0);
    step(1, 8'h00, 0);
    step(1, 8'h00, 0);
    step(0, 8'h00, 1);
    chk("post_rst_c0", extended_data, 40'h0000110000);
    pulse_reset("async_rst");

    for (int i = 0; i < NC; i++) step(1, 8'((i + 1) % 256), 0);
    step(0, 8'h00, 1);
    chk("c0", extended_data, 40'h0000010203);
    step(0, 8'h00, 1);
    chk("c1", extended_data, 40'h0001020304);
    step(0, 8'h00, 1);
    chk("c2", extended_data, 40'h0102030405);
    while (rd <= 100) step(0, 8'h00, 1);
    for (int i = 0; i < 10; i++) begin
      step(0, 8'h00, 0);
      chk("hold", extended_data, 40'h6364656667);
    end
    step(0, 8'h00, 1);
    chk("c101", extended_data, 40'h6465666768);
    while (rd < 638) step(0, 8'h00, 1);
    step(0, 8'h00, 1);
    chk("c638", extended_data, 40'h7D7E7F8000);
    step(0, 8'h00, 1);
    chk("c639", extended_data, 40'h7E7F800000);
    step(0, 8'h00, 1);
    chk("wrap_c0", extended_data, 40'h0000010203);

    for (int i = 0; i < 3; i++) step(0, 8'hEE, 0);
    step(0, 8'h00, 1);
    chk("wr_hold_c1", extended_data, 40'h0001020304);
    step(1, 8'h01, 0);
    step(1, 8'h02, 0);
    step(1, 8'h03, 1);
    step(1, 8'h04, 1);
    step(1, 8'h05, 1);
    step(1, 8'hAA, 1);
    chk("rbw_c5", extended_data, 40'h0405060708);

    while (rd <= 300) step(0, 8'h00, 1);
    pulse_reset("mid_rst");
    step(0, 8'h00, 1);
    chk("mid_c0", extended_data, 40'h0000010203);
    step(1, 8'h55, 0);
    step(0, 8'h00, 1);
    chk("new_c1", extended_data, 40'h0055020304);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1);
    chk("new_c5", extended_data, 40'h0405AA0708);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/row_buffer_5tap.md
Name: row_buffer_5tap

Overview:
- Single-line pixel buffer for the 5x5 Gaussian blur front end.
- One instance holds one image row of 8-bit grayscale pixels.
- It returns a 5-pixel horizontal window, zero-padded at the row edges, for each column that is read.
- The blur controller instantiates six of these and concatenates five windows into the 200-bit kernel input.

Parameters:
- PIX_W, 8: bits per pixel.
- MAX_COL, 640: pixels per row, which is the buffer depth.
- Window width is fixed at 5 taps, so extended_data is 5*PIX_W = 40 bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- data  input  PIX_W  pixel to write.
- write_en  input  1  when high, store data at the write pointer and advance it.
- read_en  input  1  when high, output the window for the read pointer and advance it.
- extended_data  output  5*PIX_W  registered window {p[c-2], p[c-1], p[c], p[c+1], p[c+2]}, MSB byte first.

Behaviour:
- Storage: MAX_COL x PIX_W array. Contents are not cleared by reset and are undefined until written.
- Write pointer wr_col, range 0..MAX_COL-1.
  - On a clk edge with write_en=1: mem[wr_col] <= data.
  - wr_col increments, wrapping MAX_COL-1 -> 0.
  - With write_en=0, the pointer holds.
- Read pointer rd_col, range 0..MAX_COL-1.
  - On a clk edge with read_en=1, extended_data is loaded with the window centred on rd_col.
  - rd_col then increments, wrapping MAX_COL-1 -> 0.
  - With read_en=0, rd_col and extended_data hold.
- Latency: 1 cycle. The window for column c appears on extended_data directly after the edge that sampled read_en=1 with rd_col=c.
- Window byte mapping:
  - [39:32] = p[c-2]
  - [31:24] = p[c-1]
  - [23:16] = p[c]
  - [15:8] = p[c+1]
  - [7:0] = p[c+2]
- Edge padding: any tap index <0 or >MAX_COL-1 reads as 0. This applies to columns 0, 1, MAX_COL-2 and MAX_COL-1. No wrap-around between row ends.
- Simultaneous read and write in the same cycle are allowed; the two pointers are independent.
- Read/write hazard: if a read tap addresses the location being written in the same cycle, the read returns the old content (read-before-write).
- Reset (async, any time, including mid-row): wr_col=0, rd_col=0, extended_data=0. Memory is untouched.
- No overflow or underflow flags. The controller is responsible for not reading pixels that have not been written yet.
- Implementation is free to use a register array with 5 read taps, or a RAM plus a shift-window prefetch, provided the cycle behaviour above holds exactly.

Test Plan:
- Reset:
  - Assert reset asynchronously (no clk edge) -> extended_data=0x0000000000 immediately.
  - After deassert, pointers are 0; verify by writing pixel 0x11, then reading column 0 -> 0x0000110000 (p1, p2 still unwritten, so write 0 to them first).
- Full-row fill and left edge:
  - Write 640 pixels with p[i]=(i+1) mod 256, then read.
  - Col 0 -> 0x0000010203.
  - Col 1 -> 0x0001020304.
  - Col 2 -> 0x0102030405.
  - Each result appears one cycle after its read_en edge.
- Right edge, same data:
  - Col 638 -> 0x7D7E7F8000.
  - Col 639 -> 0x7E7F800000.
  - The next read wraps to col 0 -> 0x0000010203.
- Hold:
  - Deassert read_en for 10 cycles mid-row after col 100 -> extended_data stays 0x6364656667.
  - The next read returns col 101 = 0x6465666768.
  - Deassert write_en while writing -> wr_col holds and no memory change.
- Simultaneous read/write:
  - Rewrite col 5 with 0xAA in the same cycle that col 5 is read -> output 0x0405060708.
  - A later read of col 5 -> 0x0405AA0708.
- Mid-row reset:
  - Reset after reading col 300 -> next read returns col 0 window 0x0000010203 (memory intact).
  - Next write lands at col 0.
